// File: rtl/wr_phase_counter.sv
// Tracks each write transaction through AW/W/B phases and counts prescaled ticks spent per phase.
// State updates one cycle after an event; tick/free/full are combinational. No backpressure: events are never stalled.
module wr_phase_counter #(
    parameter int MaxWrTxns    = 4,
    parameter int CntWidth     = 8,
    parameter int PrescalerDiv = 1,
    localparam int IdxWidth    = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          alloc_i,
    input  logic [IdxWidth-1:0]           alloc_idx_i,
    input  logic                          aw_hs_i,
    input  logic [IdxWidth-1:0]           aw_idx_i,
    input  logic                          w_first_i,
    input  logic                          w_last_i,
    input  logic [IdxWidth-1:0]           w_idx_i,
    input  logic                          b_hs_i,
    input  logic [IdxWidth-1:0]           b_idx_i,
    output logic                          tick_o,
    output logic [MaxWrTxns*3-1:0]        phase_o,
    output logic [MaxWrTxns*CntWidth-1:0] aw_cnt_o,
    output logic [MaxWrTxns*CntWidth-1:0] wwait_cnt_o,
    output logic [MaxWrTxns*CntWidth-1:0] wburst_cnt_o,
    output logic [MaxWrTxns*CntWidth-1:0] bwait_cnt_o,
    output logic [MaxWrTxns-1:0]          sat_o,
    output logic [IdxWidth-1:0]           free_idx_o,
    output logic                          full_o,
    output logic                          proto_err_o
);

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_AW_PEND = 3'd1;
    localparam logic [2:0] PH_W_WAIT  = 3'd2;
    localparam logic [2:0] PH_W_BURST = 3'd3;
    localparam logic [2:0] PH_B_WAIT  = 3'd4;

    logic [2:0]          phase_q [MaxWrTxns];
    logic [2:0]          phase_d [MaxWrTxns];
    logic [CntWidth-1:0] aw_cnt_q [MaxWrTxns];
    logic [CntWidth-1:0] wwait_cnt_q [MaxWrTxns];
    logic [CntWidth-1:0] wburst_cnt_q [MaxWrTxns];
    logic [CntWidth-1:0] bwait_cnt_q [MaxWrTxns];
    logic [MaxWrTxns-1:0] sat_q;
    logic [MaxWrTxns-1:0] alloc_hit, aw_hit, w_hit, b_hit, alloc_ok, viol;
    logic                 proto_err_q;

    generate
        if (PrescalerDiv > 1) begin : g_presc
            localparam int PsWidth = $clog2(PrescalerDiv);
            logic [PsWidth-1:0] ps_q;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    ps_q <= '0;
                end else if (ps_q == PsWidth'(PrescalerDiv - 1)) begin
                    ps_q <= '0;
                end else begin
                    ps_q <= ps_q + PsWidth'(1);
                end
            end
            assign tick_o = (ps_q == PsWidth'(PrescalerDiv - 1));
        end else begin : g_no_presc
            assign tick_o = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            for (int i = 0; i < MaxWrTxns; i++) phase_q[i] <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Every event is judged against the registered phase of the entry it names;
    // the only same-entry combination that chains is alloc + AW handshake.
    always_comb begin
        for (int i = 0; i < MaxWrTxns; i++) begin
            alloc_hit[i] = alloc_i && (alloc_idx_i == IdxWidth'(i));
            aw_hit[i]    = aw_hs_i && (aw_idx_i == IdxWidth'(i));
            w_hit[i]     = (w_first_i || w_last_i) && (w_idx_i == IdxWidth'(i));
            b_hit[i]     = b_hs_i && (b_idx_i == IdxWidth'(i));
            phase_d[i]   = phase_q[i];
            alloc_ok[i]  = 1'b0;
            viol[i]      = (alloc_hit[i] && phase_q[i] != PH_IDLE)
                         || (aw_hit[i] && !(phase_q[i] == PH_AW_PEND
                                            || (phase_q[i] == PH_IDLE && alloc_hit[i])))
                         || (w_hit[i] && (w_first_i ? phase_q[i] != PH_W_WAIT
                                                    : phase_q[i] != PH_W_BURST))
                         || (b_hit[i] && phase_q[i] != PH_B_WAIT);
            case (phase_q[i])
                PH_IDLE: begin
                    if (alloc_hit[i]) begin
                        alloc_ok[i] = 1'b1;
                        phase_d[i]  = aw_hit[i] ? PH_W_WAIT : PH_AW_PEND;
                    end
                end
                PH_AW_PEND: if (aw_hit[i]) phase_d[i] = PH_W_WAIT;
                PH_W_WAIT: begin
                    if (w_hit[i] && w_first_i) phase_d[i] = w_last_i ? PH_B_WAIT : PH_W_BURST;
                end
                PH_W_BURST: begin
                    if (w_hit[i] && w_last_i && !w_first_i) phase_d[i] = PH_B_WAIT;
                end
                PH_B_WAIT: if (b_hit[i]) phase_d[i] = PH_IDLE;
                default: phase_d[i] = PH_IDLE;
            endcase
        end
    end

    // Counters follow the registered phase, so the phase being left still gets this cycle's tick.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            for (int i = 0; i < MaxWrTxns; i++) begin
                aw_cnt_q[i]     <= '0;
                wwait_cnt_q[i]  <= '0;
                wburst_cnt_q[i] <= '0;
                bwait_cnt_q[i]  <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < MaxWrTxns; i++) begin
                if (alloc_ok[i]) begin
                    aw_cnt_q[i]     <= '0;
                    wwait_cnt_q[i]  <= '0;
                    wburst_cnt_q[i] <= '0;
                    bwait_cnt_q[i]  <= '0;
                    sat_q[i]        <= 1'b0;
                end else if (tick_o) begin
                    case (phase_q[i])
                        PH_AW_PEND: begin
                            if (&aw_cnt_q[i]) sat_q[i] <= 1'b1;
                            else aw_cnt_q[i] <= aw_cnt_q[i] + CntWidth'(1);
                        end
                        PH_W_WAIT: begin
                            if (&wwait_cnt_q[i]) sat_q[i] <= 1'b1;
                            else wwait_cnt_q[i] <= wwait_cnt_q[i] + CntWidth'(1);
                        end
                        PH_W_BURST: begin
                            if (&wburst_cnt_q[i]) sat_q[i] <= 1'b1;
                            else wburst_cnt_q[i] <= wburst_cnt_q[i] + CntWidth'(1);
                        end
                        PH_B_WAIT: begin
                            if (&bwait_cnt_q[i]) sat_q[i] <= 1'b1;
                            else bwait_cnt_q[i] <= bwait_cnt_q[i] + CntWidth'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            proto_err_q <= 1'b0;
        end else if (!flush_i && (|viol)) begin
            proto_err_q <= 1'b1;
        end
    end

    always_comb begin
        phase_o      = '0;
        aw_cnt_o     = '0;
        wwait_cnt_o  = '0;
        wburst_cnt_o = '0;
        bwait_cnt_o  = '0;
        free_idx_o   = '0;
        full_o       = 1'b1;
        for (int i = 0; i < MaxWrTxns; i++) begin
            phase_o[i*3 +: 3]                  = phase_q[i];
            aw_cnt_o[i*CntWidth +: CntWidth]     = aw_cnt_q[i];
            wwait_cnt_o[i*CntWidth +: CntWidth]  = wwait_cnt_q[i];
            wburst_cnt_o[i*CntWidth +: CntWidth] = wburst_cnt_q[i];
            bwait_cnt_o[i*CntWidth +: CntWidth]  = bwait_cnt_q[i];
        end
        for (int i = MaxWrTxns - 1; i >= 0; i--) begin
            if (phase_q[i] == PH_IDLE) begin
                free_idx_o = IdxWidth'(i);
                full_o     = 1'b0;
            end
        end
    end

    assign sat_o       = sat_q;
    assign proto_err_o = proto_err_q;

endmodule
